// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, helper functions and state typedefs.
// The SHA-224 IV is always present here; whether the core can select it
// depends on the SHA224_MODE_EN macro in sha256_stream_core.
package sha256_pkg;

  // Working variables / chaining value: index 7 = a/H0 ... index 0 = h/H7,
  // so the packed vector reads H0 in [255:224] without any reordering.
  typedef logic [7:0][31:0] state_t;

  // Message schedule window: index 15 = W[t] (oldest), index 0 = newest.
  typedef logic [15:0][31:0] sched_t;

  localparam state_t SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam state_t SHA224_IV = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round plus one message-schedule step.
// Chained ROUNDS_PER_CLK times inside sha256_stream_core.
module sha256_round
  import sha256_pkg::*;
(
  input  state_t     st,
  input  sched_t     w,
  input  logic [5:0] idx,
  output state_t     st_next,
  output sched_t     w_next
);

  logic [31:0] t1;
  logic [31:0] t2;
  logic [31:0] w_new;

  // Compression round on a..h and expansion of W[t+16] into the window tail
  always_comb begin
    t1      = st[0] + bsig1(st[3]) + ch(st[3], st[2], st[1]) + K[idx] + w[15];
    t2      = bsig0(st[7]) + maj(st[7], st[6], st[5]);
    st_next = {t1 + t2, st[7], st[6], st[5], st[4] + t1, st[3], st[2], st[1]};
    w_new   = ssig1(w[1]) + w[6] + ssig0(w[14]) + w[15];
    w_next  = {w[14:0], w_new};
  end

endmodule

// File: rtl/sha256_stream_core.sv
// SHA-256 streaming core: 32-bit word stream in, 256-bit digest out.
// Optional macro SHA224_MODE_EN adds i_sha224 and SHA-224 output truncation.
//
// state  | meaning
// -------+-----------------------------------------------------------
// LOAD   | accept 16 words into the schedule, pick chaining value
// ROUND  | ROUNDS_PER_CLK rounds per cycle for ROUND_CYC cycles
// ADD    | fold working vars into the chain, capture digest if last
// OUT    | present digest until the consumer takes it
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CLK = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic [31:0]  i_data,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_first,
  input  logic         i_last,
`ifdef SHA224_MODE_EN
  input  logic         i_sha224,
`endif
  output logic [255:0] o_digest,
  output logic         o_digest_valid,
  input  logic         i_digest_ready,
  output logic         o_busy,
  output logic         o_irq
);

  localparam int ROUND_CYC = 64 / ROUNDS_PER_CLK;
  localparam int RCW       = $clog2(ROUND_CYC);

  if (ROUNDS_PER_CLK != 1 && ROUNDS_PER_CLK != 2 && ROUNDS_PER_CLK != 4 &&
      ROUNDS_PER_CLK != 8 && ROUNDS_PER_CLK != 16) begin : g_bad_rpc
    $error("sha256_stream_core: ROUNDS_PER_CLK must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {S_LOAD, S_ROUND, S_ADD, S_OUT} fsm_t;

  fsm_t           state_q, state_d;
  logic [3:0]     wcnt_q;
  logic [RCW-1:0] rcnt_q;
  sched_t         sched_q;
  state_t         vars_q, chain_q, digest_q, sum_c, iv_sel;
  logic           last_q, irq_q, run_q, accept, trunc;

  state_t st_c [ROUNDS_PER_CLK+1];
  sched_t w_c  [ROUNDS_PER_CLK+1];

  assign st_c[0] = vars_q;
  assign w_c[0]  = sched_q;

  for (genvar k = 0; k < ROUNDS_PER_CLK; k++) begin : g_rnd
    logic [5:0] idx;
    assign idx = 6'(32'(rcnt_q) * ROUNDS_PER_CLK + k);
    sha256_round u_round (
      .st      (st_c[k]),
      .w       (w_c[k]),
      .idx     (idx),
      .st_next (st_c[k+1]),
      .w_next  (w_c[k+1])
    );
  end

`ifdef SHA224_MODE_EN
  logic mode_q;
  assign iv_sel = i_sha224 ? SHA224_IV : SHA256_IV;
  assign trunc  = mode_q;

  // Hash mode is chosen on the first word of a message and held across its blocks
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                           mode_q <= 1'b0;
    else if (i_clr)                         mode_q <= 1'b0;
    else if (accept && wcnt_q == 4'd0 && i_first) mode_q <= i_sha224;
  end
`else
  assign iv_sel = SHA256_IV;
  assign trunc  = 1'b0;
`endif

  // A word moves only while loading; a soft clear wins over the handshake
  assign accept = i_valid && run_q && (state_q == S_LOAD) && !i_clr;

  // Per-word modular sum of chain and working variables
  always_comb begin
    for (int i = 0; i < 8; i++) sum_c[i] = chain_q[i] + vars_q[i];
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_LOAD;
    else          state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d        = state_q;
    o_ready        = 1'b0;
    o_busy         = 1'b0;
    o_digest_valid = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        o_ready = run_q;
        if (accept && wcnt_q == 4'd15) state_d = S_ROUND;
      end
      S_ROUND: begin
        o_busy = 1'b1;
        if (rcnt_q == RCW'(ROUND_CYC - 1)) state_d = S_ADD;
      end
      S_ADD: begin
        o_busy  = 1'b1;
        state_d = last_q ? S_OUT : S_LOAD;
      end
      S_OUT: begin
        o_busy         = 1'b1;
        o_digest_valid = 1'b1;
        if (i_digest_ready) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
    if (i_clr) state_d = S_LOAD;
  end

  // Datapath: schedule load, round iteration, chaining and digest capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_q    <= 1'b0;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      sched_q  <= '0;
      vars_q   <= '0;
      chain_q  <= SHA256_IV;
      digest_q <= '0;
      last_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      irq_q <= (state_q == S_ADD) && last_q && !i_clr;
      if (i_clr) begin
        wcnt_q  <= '0;
        rcnt_q  <= '0;
        chain_q <= SHA256_IV;
        last_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_LOAD: if (accept) begin
            sched_q <= {sched_q[14:0], i_data};
            wcnt_q  <= wcnt_q + 4'd1;
            if (wcnt_q == 4'd0) begin
              if (i_first) begin
                chain_q <= iv_sel;
                vars_q  <= iv_sel;
              end else begin
                vars_q  <= chain_q;
              end
            end
            if (wcnt_q == 4'd15) last_q <= i_last;
          end
          S_ROUND: begin
            vars_q  <= st_c[ROUNDS_PER_CLK];
            sched_q <= w_c[ROUNDS_PER_CLK];
            rcnt_q  <= rcnt_q + RCW'(1);
          end
          S_ADD: begin
            chain_q <= sum_c;
            if (last_q) digest_q <= trunc ? {sum_c[7:1], 32'h0} : sum_c;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_digest = digest_q;
  assign o_irq    = irq_q;

endmodule

// File: tb/tb_sha256_stream_core.sv
// Scoreboard bench for sha256_stream_core: expected digests are queued when a
// message is sent and compared when the digest handshake occurs.
// Latency is counted in clock edges after the edge that takes word 15.
module tb_sha256_stream_core;
  parameter int RPC  = 1;
  localparam int RCYC = 64 / RPC;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {{15{32'h0}}, 32'h000001c0};

  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
`ifdef SHA224_MODE_EN
  localparam logic [255:0] D_224   = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  logic i_sha224 = 1'b0;
`endif

  logic         i_clk = 1'b0, i_rst_n = 1'b0, i_clr = 1'b0;
  logic [31:0]  i_data = '0;
  logic         i_valid = 1'b0, i_first = 1'b0, i_last = 1'b0, i_digest_ready = 1'b0;
  logic         o_ready, o_digest_valid, o_busy, o_irq;
  logic [255:0] o_digest;

  typedef struct { logic [255:0] dig; bit care; string tag; } exp_t;
  exp_t         sb_q[$];
  exp_t         mon_e;
  int           n_vec = 0, n_miss = 0, irq_seen = 0;
  logic         prev_valid = 1'b0;

  always #5 i_clk = ~i_clk;

  sha256_stream_core #(.ROUNDS_PER_CLK(RPC)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_clr          (i_clr),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_first        (i_first),
    .i_last         (i_last),
`ifdef SHA224_MODE_EN
    .i_sha224       (i_sha224),
`endif
    .o_digest       (o_digest),
    .o_digest_valid (o_digest_valid),
    .i_digest_ready (i_digest_ready),
    .o_busy         (o_busy),
    .o_irq          (o_irq)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_exp(input logic [255:0] d, input bit care, input string tag);
    exp_t e;
    e.dig = d; e.care = care; e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the word was taken
  task automatic send_word(input logic [31:0] d, input logic f, input logic l);
    int n = 0;
    i_valid = 1'b1; i_data = d; i_first = f; i_last = l;
    @(negedge i_clk);
    while (!o_ready && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    check_eq("word_accept", o_ready, 1);
    tick();
    i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
  endtask

  task automatic send_block(input logic [511:0] blk, input logic f, input logic l, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      send_word(blk[511-32*i -: 32], (i == 0) ? f : 1'b0, (i == 15) ? l : 1'b0);
    end
  endtask

  // Starts right after the edge that took word 15; returns at a negedge
  task automatic wait_digest(input string tag);
    int n = 0;
    @(negedge i_clk);
    while (!o_digest_valid && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    check_eq({tag, "_valid"}, o_digest_valid, 1);
    check_eq({tag, "_latency"}, n, RCYC + 1);
  endtask

  // Scoreboard / irq monitor, sampled on the falling edge
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (o_irq) irq_seen++;
      if (o_digest_valid && !prev_valid) begin
        check_eq("irq_on_rise", o_irq, 1);
        if (sb_q.size() == 0) check_eq("unexpected_digest", o_digest_valid, 0);
      end else if (o_irq) begin
        check_eq("irq_spurious", o_irq, 0);
      end
      if (o_digest_valid && i_digest_ready && !i_clr && sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        if (mon_e.care) check_eq(mon_e.tag, o_digest, mon_e.dig);
      end
      prev_valid = o_digest_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, %0d vectors applied, %0d miscompares", n_vec, n_miss);
    $fatal(1);
  end

  initial begin
    logic [255:0] d0;
    int           irq0;

    // Reset values
    repeat (3) @(negedge i_clk);
    check_eq("rst_ready", o_ready, 0);
    check_eq("rst_digest", o_digest, 0);
    check_eq("rst_valid", o_digest_valid, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_irq", o_irq, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_eq("ready_before_clk", o_ready, 0);
    tick();
    check_eq("ready_after_release", o_ready, 1);

    // "abc", single block; digest_ready held high throughout (ignored outside OUT)
    i_digest_ready = 1'b1;
    push_exp(D_ABC, 1, "abc_digest");
    send_block(BLK_ABC, 1, 1, 0);
    check_eq("abc_busy_in_round", o_busy, 1);
    check_eq("abc_ready_in_round", o_ready, 0);
    wait_digest("abc");
    tick();
    check_eq("abc_ready_after_out", o_ready, 1);
    check_eq("abc_valid_drop", o_digest_valid, 0);
    check_eq("abc_digest_hold", o_digest, D_ABC);

    // Empty message
    push_exp(D_EMPTY, 1, "empty_digest");
    send_block(BLK_EMPTY, 1, 1, 0);
    wait_digest("empty");
    tick();

    // Two-block message, random valid gaps, consumer stalls 10 cycles
    i_digest_ready = 1'b0;
    irq0 = irq_seen;
    push_exp(D_TWO, 1, "two_digest");
    send_block(BLK_TWO1, 1, 0, 1);
    send_block(BLK_TWO2, 0, 1, 1);
    wait_digest("two");
    d0 = o_digest;
    check_eq("two_digest_early", d0, D_TWO);
    repeat (10) begin
      @(negedge i_clk);
      check_eq("two_digest_stable", o_digest, d0);
      check_eq("two_valid_held", o_digest_valid, 1);
    end
    tick();
    i_digest_ready = 1'b1;
    tick();
    check_eq("two_irq_count", irq_seen - irq0, 1);
    check_eq("two_ready_after_out", o_ready, 1);

    // Midstate: block 1 delivered alone, then a non-first block continues from it
    push_exp('0, 0, "mid_first");
    send_block(BLK_TWO1, 1, 1, 0);
    wait_digest("mid1");
    tick();
    push_exp(D_TWO, 1, "midstate_digest");
    send_block(BLK_TWO2, 0, 1, 0);
    wait_digest("mid2");
    tick();

    // Soft clear mid-ROUND, then clear beating a word handshake, then "abc"
    send_block(BLK_TWO1, 1, 0, 0);
    repeat (RCYC / 2) tick();
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    check_eq("clr_ready", o_ready, 1);
    check_eq("clr_busy", o_busy, 0);
    i_valid = 1'b1; i_data = 32'hdeadbeef; i_first = 1'b1; i_clr = 1'b1;
    tick();
    i_valid = 1'b0; i_first = 1'b0; i_clr = 1'b0;
    push_exp(D_ABC, 1, "after_clr_digest");
    send_block(BLK_ABC, 1, 1, 0);
    wait_digest("after_clr");
    tick();

    // Async reset mid-ROUND aborts silently
    send_block(BLK_ABC, 1, 1, 0);
    repeat (3) tick();
    i_rst_n = 1'b0;
    #1;
    check_eq("rst_round_busy", o_busy, 0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Async reset while presenting a digest
    i_digest_ready = 1'b0;
    push_exp('0, 0, "rst_out");
    send_block(BLK_ABC, 1, 1, 0);
    wait_digest("rst_out");
    tick();
    i_rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", o_digest_valid, 0);
    check_eq("rst_out_digest", o_digest, 0);
    sb_q.delete();
    tick();
    i_rst_n = 1'b1;
    tick();
    check_eq("rst_out_ready", o_ready, 1);
    i_digest_ready = 1'b1;

    // Normal operation after the aborts
    push_exp(D_ABC, 1, "recover_digest");
    send_block(BLK_ABC, 1, 1, 0);
    wait_digest("recover");
    tick();

`ifdef SHA224_MODE_EN
    i_sha224 = 1'b1;
    push_exp(D_224, 1, "sha224_digest");
    send_block(BLK_ABC, 1, 1, 0);
    i_sha224 = 1'b0;
    wait_digest("sha224");
    tick();
    push_exp(D_ABC, 1, "sha256_after_224");
    send_block(BLK_ABC, 1, 1, 0);
    wait_digest("sha256_after_224");
    tick();
`endif

    check_eq("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
